// File: rtl/multicycle_seq.sv
// Multi-cycle execution sequencer: fetches over a valid/ready port, holds the instruction
// for decode/ALU, runs loads/stores over a valid/ready data port, and owns PC/counters/halt.
module multicycle_seq #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int              CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  output logic [XLEN-1:0]  ifu_req_addr,
  input  logic             ifu_rsp_valid,
  input  logic [31:0]      ifu_rsp_inst,
  output logic [31:0]      inst,
  output logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  next_pc,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_ebreak,
  input  logic             reg_wen_dec,
  output logic             lsu_req_valid,
  input  logic             lsu_req_ready,
  output logic             lsu_req_we,
  input  logic             lsu_rsp_valid,
  input  logic [XLEN-1:0]  lsu_rsp_data,
  output logic [XLEN-1:0]  lsu_rdata,
  output logic             reg_wen,
  output logic             commit,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] mcycle,
  output logic [CNT_W-1:0] minstret
);

  typedef enum logic [2:0] {
    FETCH_REQ,
    FETCH_WAIT,
    EXEC,
    MEM_REQ,
    MEM_WAIT,
    WB,
    HALT
  } state_t;

  localparam logic [31:0]      NOP_INST = 32'h0000_0013;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;

  // The reset state is FETCH_REQ, so the fetch request is masked while reset is held.
  assign ifu_req_valid = (state == FETCH_REQ) && !rst;
  assign ifu_req_addr  = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= FETCH_REQ;
      pc            <= RESET_PC;
      inst          <= NOP_INST;
      lsu_rdata     <= '0;
      lsu_req_valid <= 1'b0;
      lsu_req_we    <= 1'b0;
      reg_wen       <= 1'b0;
      commit        <= 1'b0;
      halted        <= 1'b0;
      halt_cause    <= 2'b00;
      mcycle        <= '0;
      minstret      <= '0;
    end else begin
      commit  <= 1'b0;
      reg_wen <= 1'b0;
      if (state != HALT) begin
        mcycle <= mcycle + CNT_ONE;
      end
      case (state)
        FETCH_REQ: begin
          if (ifu_req_ready) begin
            state <= FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (ifu_rsp_valid) begin
            inst  <= ifu_rsp_inst;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (is_ebreak) begin
            // ebreak retires without a writeback and leaves pc on itself.
            state      <= HALT;
            halted     <= 1'b1;
            halt_cause <= 2'b01;
            commit     <= 1'b1;
            minstret   <= minstret + CNT_ONE;
          end else if (is_load || is_store) begin
            state         <= MEM_REQ;
            lsu_req_valid <= 1'b1;
            lsu_req_we    <= is_store;
          end else begin
            state   <= WB;
            commit  <= 1'b1;
            reg_wen <= reg_wen_dec;
          end
        end
        MEM_REQ: begin
          if (lsu_req_ready) begin
            state         <= MEM_WAIT;
            lsu_req_valid <= 1'b0;
          end
        end
        MEM_WAIT: begin
          if (lsu_rsp_valid) begin
            if (!lsu_req_we) begin
              lsu_rdata <= lsu_rsp_data;
            end
            lsu_req_we <= 1'b0;
            state      <= WB;
            commit     <= 1'b1;
            reg_wen    <= reg_wen_dec;
          end
        end
        WB: begin
          minstret <= minstret + CNT_ONE;
          pc       <= next_pc;
          if (next_pc[1:0] != 2'b00) begin
            state      <= HALT;
            halted     <= 1'b1;
            halt_cause <= 2'b10;
          end else begin
            state <= FETCH_REQ;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= FETCH_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed bench for multicycle_seq: table of single-instruction runs from reset,
// plus reset-in-MEM_WAIT and narrow-counter wrap sequences.
module tb_multicycle_seq;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_req_addr, ifu_rsp_inst, inst, pc, next_pc;
  logic        is_load, is_store, is_ebreak, reg_wen_dec;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_we, lsu_rsp_valid;
  logic [31:0] lsu_rsp_data, lsu_rdata;
  logic        reg_wen, commit, halted;
  logic [1:0]  halt_cause;
  logic [63:0] mcycle, minstret;

  multicycle_seq dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst),
    .inst(inst), .pc(pc), .next_pc(next_pc),
    .is_load(is_load), .is_store(is_store), .is_ebreak(is_ebreak), .reg_wen_dec(reg_wen_dec),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_we(lsu_req_we),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rdata(lsu_rdata),
    .reg_wen(reg_wen), .commit(commit), .halted(halted), .halt_cause(halt_cause),
    .mcycle(mcycle), .minstret(minstret)
  );

  // Narrow-counter instance with always-ready memories running aligned ALU ops.
  logic        rst4 = 1'b1;
  logic        ifu_req_valid4, lsu_req_valid4, lsu_req_we4, reg_wen4, commit4, halted4;
  logic [31:0] ifu_req_addr4, inst4, pc4, next_pc4, lsu_rdata4;
  logic [1:0]  halt_cause4;
  logic [3:0]  mcycle4, minstret4;
  assign next_pc4 = pc4 + 32'd4;

  multicycle_seq #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst4),
    .ifu_req_valid(ifu_req_valid4), .ifu_req_ready(1'b1), .ifu_req_addr(ifu_req_addr4),
    .ifu_rsp_valid(1'b1), .ifu_rsp_inst(32'h0000_0013),
    .inst(inst4), .pc(pc4), .next_pc(next_pc4),
    .is_load(1'b0), .is_store(1'b0), .is_ebreak(1'b0), .reg_wen_dec(1'b1),
    .lsu_req_valid(lsu_req_valid4), .lsu_req_ready(1'b1), .lsu_req_we(lsu_req_we4),
    .lsu_rsp_valid(1'b1), .lsu_rsp_data(32'h0), .lsu_rdata(lsu_rdata4),
    .reg_wen(reg_wen4), .commit(commit4), .halted(halted4), .halt_cause(halt_cause4),
    .mcycle(mcycle4), .minstret(minstret4)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string what, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", what, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] name;
    logic [31:0] ins;
    logic        ld, st, eb, wd;
    int          ifu_stall, lsu_stall;
    logic [31:0] npc, rdata;
    int          exp_cyc;
    logic        exp_wen;
    logic [31:0] exp_pc;
    int          exp_mcycle, exp_minstret;
    logic        exp_halted;
    logic [1:0]  exp_cause;
    logic [31:0] exp_rdata;
    logic        exp_we;
  } vec_t;

  vec_t vecs[9];

  task automatic idle_inputs();
    ifu_req_ready = 0; ifu_rsp_valid = 0; lsu_req_ready = 0; lsu_rsp_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int c, commit_cyc, valid_cnt, addr_bad, stray, ifu_wait, lsu_wait, hold_req;
    logic fetch_due, lsu_pending, wen_at, we_seen;
    logic [31:0] rdata_at, inst_at;
    string tag;
    commit_cyc = 0; valid_cnt = 0; addr_bad = 0; stray = 0; ifu_wait = 0; lsu_wait = 0;
    hold_req = 0; fetch_due = 0; lsu_pending = 0; wen_at = 0; we_seen = 0;
    rdata_at = '0; inst_at = '0;
    is_load = v.ld; is_store = v.st; is_ebreak = v.eb; reg_wen_dec = v.wd;
    next_pc = v.npc; ifu_rsp_inst = v.ins; lsu_rsp_data = v.rdata;
    do_reset();
    for (c = 1; c <= 40 && commit_cyc == 0; c++) begin
      if (commit) begin
        commit_cyc = c; wen_at = reg_wen; rdata_at = lsu_rdata; inst_at = inst;
      end else if (reg_wen) begin
        stray++;
      end
      ifu_rsp_valid = 1'b0;
      if (fetch_due) begin
        ifu_rsp_valid = 1'b1;
        fetch_due = 1'b0;
      end
      ifu_req_ready = 1'b0;
      if (ifu_req_valid) begin
        valid_cnt++;
        if (ifu_req_addr !== RPC) addr_bad++;
        if (ifu_wait >= v.ifu_stall) begin
          ifu_req_ready = 1'b1;
          fetch_due = 1'b1;
        end else begin
          ifu_wait++;
        end
      end
      lsu_rsp_valid = 1'b0;
      if (lsu_pending) begin
        if (lsu_wait >= v.lsu_stall) begin
          lsu_rsp_valid = 1'b1;
          lsu_pending = 1'b0;
        end else begin
          lsu_wait++;
        end
      end
      lsu_req_ready = 1'b0;
      if (lsu_req_valid) begin
        lsu_req_ready = 1'b1;
        lsu_pending = 1'b1;
        lsu_wait = 0;
        we_seen = lsu_req_we;
      end
      @(negedge clk);
    end
    idle_inputs();
    tag = $sformatf("v%0d %s", id, v.name);
    chk({tag, " commit_cycle"}, 64'(commit_cyc), 64'(v.exp_cyc));
    chk({tag, " reg_wen@commit"}, 64'(wen_at), 64'(v.exp_wen));
    chk({tag, " stray_reg_wen"}, 64'(stray), 64'd0);
    chk({tag, " lsu_rdata@commit"}, 64'(rdata_at), 64'(v.exp_rdata));
    chk({tag, " lsu_req_we"}, 64'(we_seen), 64'(v.exp_we));
    chk({tag, " inst@commit"}, 64'(inst_at), 64'(v.ins));
    chk({tag, " ifu_valid_cycles"}, 64'(valid_cnt), 64'(v.ifu_stall + 1));
    chk({tag, " ifu_addr_bad"}, 64'(addr_bad), 64'd0);
    chk({tag, " pc"}, 64'(pc), 64'(v.exp_pc));
    chk({tag, " mcycle"}, mcycle, 64'(v.exp_mcycle));
    chk({tag, " minstret"}, minstret, 64'(v.exp_minstret));
    chk({tag, " halted"}, 64'(halted), 64'(v.exp_halted));
    chk({tag, " halt_cause"}, 64'(halt_cause), 64'(v.exp_cause));
    if (v.exp_halted) begin
      repeat (5) begin
        @(negedge clk);
        if (ifu_req_valid || lsu_req_valid) hold_req++;
      end
      chk({tag, " halt_requests"}, 64'(hold_req), 64'd0);
      chk({tag, " halt_mcycle_frozen"}, mcycle, 64'(v.exp_mcycle));
      chk({tag, " halt_pc"}, 64'(pc), 64'(v.exp_pc));
    end
  endtask

  initial begin
    //        name       ins            ld st eb wd ifs lss npc            rdata         cyc wen pc             mcy ins hlt cause rdata         we
    vecs[0] = '{"addi",    32'h00500093, 0, 0, 0, 1, 0, 0, RPC + 32'd4,   32'h0,        4, 1, RPC + 32'd4,   4, 1, 0, 2'd0, 32'h0,        0};
    vecs[1] = '{"addi_stl",32'h00500093, 0, 0, 0, 1, 3, 0, RPC + 32'd4,   32'h0,        7, 1, RPC + 32'd4,   7, 1, 0, 2'd0, 32'h0,        0};
    vecs[2] = '{"lw",      32'h0000a083, 1, 0, 0, 1, 0, 0, RPC + 32'd4,   32'h12345678, 6, 1, RPC + 32'd4,   6, 1, 0, 2'd0, 32'h12345678, 0};
    vecs[3] = '{"lw_slow", 32'h0000a083, 1, 0, 0, 1, 0, 2, RPC + 32'd4,   32'hDEADBEEF, 8, 1, RPC + 32'd4,   8, 1, 0, 2'd0, 32'hDEADBEEF, 0};
    vecs[4] = '{"sw",      32'h0010a023, 0, 1, 0, 0, 0, 1, RPC + 32'd4,   32'hCAFEF00D, 7, 0, RPC + 32'd4,   7, 1, 0, 2'd0, 32'h0,        1};
    vecs[5] = '{"ebreak",  32'h00100073, 0, 0, 1, 1, 0, 0, RPC + 32'd4,   32'h0,        4, 0, RPC,           3, 1, 1, 2'd1, 32'h0,        0};
    vecs[6] = '{"eb_ld",   32'h00100073, 1, 0, 1, 1, 0, 0, RPC + 32'd4,   32'h0,        4, 0, RPC,           3, 1, 1, 2'd1, 32'h0,        0};
    vecs[7] = '{"misalign",32'h00500093, 0, 0, 0, 1, 0, 0, RPC + 32'd2,   32'h0,        4, 1, RPC + 32'd2,   4, 1, 1, 2'd2, 32'h0,        0};
    vecs[8] = '{"jump",    32'h1000006f, 0, 0, 0, 1, 1, 0, RPC + 32'h100, 32'h0,        5, 1, RPC + 32'h100, 5, 1, 0, 2'd0, 32'h0,        0};

    is_load = 0; is_store = 0; is_ebreak = 0; reg_wen_dec = 0;
    next_pc = RPC; ifu_rsp_inst = 32'h0; lsu_rsp_data = 32'h0;
    idle_inputs();

    // Reset state while rst is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ifu_req_valid", 64'(ifu_req_valid), 64'd0);
    chk("reset pc", 64'(pc), 64'(RPC));
    chk("reset inst", 64'(inst), 64'h13);
    chk("reset mcycle", mcycle, 64'd0);
    chk("reset halt_cause", 64'(halt_cause), 64'd0);

    for (int i = 0; i < 9; i++) begin
      run_vec(i, vecs[i]);
      $display("vector %0d %s done: checks=%0d failures=%0d", i, vecs[i].name, checks, failures);
    end

    // Complete one load, then assert reset while the second load sits in MEM_WAIT.
    is_load = 1; is_store = 0; is_ebreak = 0; reg_wen_dec = 1;
    next_pc = RPC + 32'd4; ifu_rsp_inst = 32'h0000a083; lsu_rsp_data = 32'hDEADBEEF;
    do_reset();
    ifu_req_ready = 1; ifu_rsp_valid = 1; lsu_req_ready = 1;
    for (int c = 1; c < 11; c++) begin
      lsu_rsp_valid = (c == 5);
      @(negedge clk);
    end
    lsu_rsp_valid = 0;
    chk("pre-reset minstret", minstret, 64'd1);
    chk("pre-reset mcycle", mcycle, 64'd10);
    chk("pre-reset lsu_rdata", 64'(lsu_rdata), 64'hDEADBEEF);
    chk("pre-reset pc", 64'(pc), 64'(RPC + 32'd4));
    rst = 1'b1;
    #1;
    chk("midreset mcycle", mcycle, 64'd0);
    chk("midreset minstret", minstret, 64'd0);
    chk("midreset lsu_rdata", 64'(lsu_rdata), 64'd0);
    chk("midreset pc", 64'(pc), 64'(RPC));
    chk("midreset inst", 64'(inst), 64'h13);
    chk("midreset valids", 64'({ifu_req_valid, lsu_req_valid, lsu_req_we, reg_wen, commit, halted}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("refetch valid", 64'(ifu_req_valid), 64'd1);
    chk("refetch addr", 64'(ifu_req_addr), 64'(RPC));
    idle_inputs();

    // 4-bit counters: five 4-cycle ALU ops in 20 cycles.
    @(negedge clk);
    rst4 = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("cnt4 mcycle wrap", 64'(mcycle4), 64'd4);
    chk("cnt4 minstret", 64'(minstret4), 64'd5);
    chk("cnt4 pc", 64'(pc4), 64'(RPC + 32'd20));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
